// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game controller: state encoding, LFSR taps, width helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package simon_pkg;

    // State encoding; the numeric values are visible on the debug state port.
    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_PLAY_ON  = 3'd1,
        S_PLAY_GAP = 3'd2,
        S_WAIT     = 3'd3,
        S_CHECK    = 3'd4,
        S_ERROR    = 3'd5,
        S_WIN      = 3'd6
    } state_t;

    localparam int LFSR_W = 16;
    localparam int TAP_A  = 15;
    localparam int TAP_B  = 13;
    localparam int TAP_C  = 12;
    localparam int TAP_D  = 10;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // One Fibonacci step: shift left, feedback into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exposes its low OUT_W bits as the random draw.
// Latency: draw reflects the current register value; it advances every tick.
// Backpressure: none, never stalls.
// Ports: clk_tick/reset (async, active-high), draw = lfsr[OUT_W-1:0].
module simon_lfsr
    import simon_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int                OUT_W = 2
) (
    input  logic             clk_tick,
    input  logic             reset,
    output logic [OUT_W-1:0] draw
);

    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk_tick or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    assign draw = lfsr[OUT_W-1:0];

endmodule

// File: rtl/simon_fsm_gen.sv
// Simon game controller: draws a MAX_LEN sequence, plays rounds on the LEDs, checks presses.
// Latency: outputs are registered; a press is judged in the CHECK tick after it is latched.
// Backpressure: none; presses outside WAIT/ERROR/WIN are dropped, never queued.
// Ports: clk_tick, reset (async, active-high), btn_valid/btn_val from the button encoder,
//        led (one-hot playback, all ones on win), error_led, win_led,
//        debug: state, round_cnt, exp_val (= expected next press).
module simon_fsm_gen
    import simon_pkg::*;
#(
    parameter int                MAX_LEN       = 16,
    parameter int                NUM_BTN       = 4,
    parameter int                HOLD_TICKS    = 6,
    parameter int                GAP_TICKS     = 2,
    parameter int                TIMEOUT_TICKS = 192,
    parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1,
    localparam int               BW            = width_of(NUM_BTN),
    localparam int               CW            = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_tick,
    input  logic               reset,
    input  logic               btn_valid,
    input  logic [BW-1:0]      btn_val,
    output logic [NUM_BTN-1:0] led,
    output logic               error_led,
    output logic               win_led,
    output logic [2:0]         state,
    output logic [CW-1:0]      round_cnt,
    output logic [BW-1:0]      exp_val
);

    localparam int IW = width_of(MAX_LEN);
    localparam int HW = width_of(HOLD_TICKS);
    localparam int GW = width_of(GAP_TICKS);
    localparam int TW = width_of(TIMEOUT_TICKS);

    localparam logic [CW-1:0]      C_ONE     = CW'(1);
    localparam logic [CW-1:0]      LAST_IDX  = CW'(MAX_LEN - 1);
    localparam logic [CW-1:0]      MAX_C     = CW'(MAX_LEN);
    localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0]      H_ONE     = HW'(1);
    localparam logic [GW-1:0]      GAP_LAST  = GW'(GAP_TICKS - 1);
    localparam logic [GW-1:0]      G_ONE     = GW'(1);
    localparam logic [TW-1:0]      TO_LAST   = TW'(TIMEOUT_TICKS - 1);
    localparam logic [TW-1:0]      T_ONE     = TW'(1);
    localparam logic [NUM_BTN-1:0] LED_ONE   = NUM_BTN'(1);

    logic [BW-1:0] draw;

    simon_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (BW)
    ) u_lfsr (
        .clk_tick (clk_tick),
        .reset    (reset),
        .draw     (draw)
    );

    // Sequence RAM: filled one entry per tick while in INIT.
    logic [BW-1:0] seq [MAX_LEN];

    state_t             cur_st, nxt_st;
    logic [CW-1:0]      fill_idx, fill_n;
    logic [CW-1:0]      play_idx, play_n;
    logic [CW-1:0]      input_idx, inp_n;
    logic [CW-1:0]      round_n;
    logic [HW-1:0]      hold_cnt, hold_n;
    logic [GW-1:0]      gap_cnt, gap_n;
    logic [TW-1:0]      to_cnt, to_n;
    logic [BW-1:0]      btn_q, btn_q_n;
    logic [NUM_BTN-1:0] led_n;
    logic               err_n, win_n;
    logic               start_play;
    logic [CW-1:0]      inp_plus1;

    assign inp_plus1 = input_idx + C_ONE;
    assign exp_val   = seq[input_idx[IW-1:0]];
    assign state     = cur_st;

    always_ff @(posedge clk_tick or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seq[i] <= '0;
            end
        end else if (cur_st == S_INIT) begin
            seq[fill_idx[IW-1:0]] <= draw;
        end
    end

    always_ff @(posedge clk_tick or posedge reset) begin
        if (reset) begin
            cur_st    <= S_INIT;
            fill_idx  <= '0;
            play_idx  <= '0;
            input_idx <= '0;
            round_cnt <= '0;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            to_cnt    <= '0;
            btn_q     <= '0;
            led       <= '0;
            error_led <= 1'b0;
            win_led   <= 1'b0;
        end else begin
            cur_st    <= nxt_st;
            fill_idx  <= fill_n;
            play_idx  <= play_n;
            input_idx <= inp_n;
            round_cnt <= round_n;
            hold_cnt  <= hold_n;
            gap_cnt   <= gap_n;
            to_cnt    <= to_n;
            btn_q     <= btn_q_n;
            led       <= led_n;
            error_led <= err_n;
            win_led   <= win_n;
        end
    end

    always_comb begin
        nxt_st     = cur_st;
        fill_n     = fill_idx;
        play_n     = play_idx;
        inp_n      = input_idx;
        round_n    = round_cnt;
        hold_n     = hold_cnt;
        gap_n      = gap_cnt;
        to_n       = to_cnt;
        btn_q_n    = btn_q;
        led_n      = led;
        err_n      = error_led;
        win_n      = win_led;
        start_play = 1'b0;

        case (cur_st)
            S_INIT: begin
                if (fill_idx == LAST_IDX) begin
                    round_n    = C_ONE;
                    play_n     = '0;
                    start_play = 1'b1;
                end else begin
                    fill_n = fill_idx + C_ONE;
                end
            end
            S_PLAY_ON: begin
                if (hold_cnt == '0) begin
                    led_n  = '0;
                    gap_n  = GAP_LAST;
                    play_n = play_idx + C_ONE;
                    nxt_st = S_PLAY_GAP;
                end else begin
                    hold_n = hold_cnt - H_ONE;
                end
            end
            S_PLAY_GAP: begin
                led_n = '0;
                if (gap_cnt == '0) begin
                    if (play_idx < round_cnt) begin
                        start_play = 1'b1;
                    end else begin
                        inp_n  = '0;
                        to_n   = '0;
                        nxt_st = S_WAIT;
                    end
                end else begin
                    gap_n = gap_cnt - G_ONE;
                end
            end
            S_WAIT: begin
                led_n = '0;
                // A press on the final tick still wins over the timeout.
                if (btn_valid) begin
                    btn_q_n = btn_val;
                    nxt_st  = S_CHECK;
                end else if (to_cnt == TO_LAST) begin
                    err_n  = 1'b1;
                    nxt_st = S_ERROR;
                end else begin
                    to_n = to_cnt + T_ONE;
                end
            end
            S_CHECK: begin
                if (btn_q != seq[input_idx[IW-1:0]]) begin
                    err_n  = 1'b1;
                    nxt_st = S_ERROR;
                end else if (inp_plus1 < round_cnt) begin
                    inp_n  = inp_plus1;
                    to_n   = '0;
                    nxt_st = S_WAIT;
                end else if (round_cnt < MAX_C) begin
                    round_n    = round_cnt + C_ONE;
                    play_n     = '0;
                    start_play = 1'b1;
                end else begin
                    win_n  = 1'b1;
                    led_n  = '1;
                    nxt_st = S_WIN;
                end
            end
            S_ERROR: begin
                err_n = 1'b1;
                // Retry keeps the drawn sequence; only the round restarts.
                if (btn_valid) begin
                    err_n      = 1'b0;
                    round_n    = C_ONE;
                    play_n     = '0;
                    start_play = 1'b1;
                end
            end
            S_WIN: begin
                led_n = '1;
                if (btn_valid) begin
                    win_n   = 1'b0;
                    led_n   = '0;
                    round_n = '0;
                    fill_n  = '0;
                    nxt_st  = S_INIT;
                end
            end
            default: begin
                nxt_st = S_INIT;
            end
        endcase

        // Common PLAY_ON entry: light the LED for the step about to be shown.
        if (start_play) begin
            nxt_st = S_PLAY_ON;
            led_n  = LED_ONE << seq[play_n[IW-1:0]];
            hold_n = HOLD_LAST;
        end
    end

endmodule

// File: tb/tb_simon_fsm_gen.sv
// Bench for simon_fsm_gen: default instance (16 steps, 4 buttons) and a small one (4 steps, 8 buttons).
// Latency: n/a.
// Backpressure: n/a.
module tb_simon_fsm_gen;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic       bv;
    logic [2:0] bval;
    logic       sel;

    logic [3:0] led_a;
    logic       err_a, win_a;
    logic [2:0] st_a;
    logic [4:0] rnd_a;
    logic [1:0] exp_a;

    logic [7:0] led_b;
    logic       err_b, win_b;
    logic [2:0] st_b;
    logic [2:0] rnd_b;
    logic [2:0] exp_b;

    logic [7:0] o_led;
    logic       o_err, o_win;
    logic [2:0] o_state;
    logic [4:0] o_round;
    logic [2:0] o_exp;

    int errors = 0;
    int checks = 0;
    int tick_no;
    int ml, nb, mask, hold, gap, tmo;
    int seq [64];

    always #5 clk = ~clk;

    simon_fsm_gen u_a (
        .clk_tick  (clk),
        .reset     (rst_a),
        .btn_valid (bv),
        .btn_val   (bval[1:0]),
        .led       (led_a),
        .error_led (err_a),
        .win_led   (win_a),
        .state     (st_a),
        .round_cnt (rnd_a),
        .exp_val   (exp_a)
    );

    simon_fsm_gen #(
        .MAX_LEN    (4),
        .NUM_BTN    (8),
        .HOLD_TICKS (1)
    ) u_b (
        .clk_tick  (clk),
        .reset     (rst_b),
        .btn_valid (bv),
        .btn_val   (bval),
        .led       (led_b),
        .error_led (err_b),
        .win_led   (win_b),
        .state     (st_b),
        .round_cnt (rnd_b),
        .exp_val   (exp_b)
    );

    assign o_led   = sel ? led_b : {4'h0, led_a};
    assign o_err   = sel ? err_b : err_a;
    assign o_win   = sel ? win_b : win_a;
    assign o_state = sel ? st_b : st_a;
    assign o_round = sel ? {2'b00, rnd_b} : rnd_a;
    assign o_exp   = sel ? exp_b : {1'b0, exp_a};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tick_no++;
    endtask

    // Generator value n ticks after reset release, straight from the shift/feedback rule.
    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] s;
        s = 16'hACE1;
        for (int k = 0; k < n; k++) begin
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        end
        return s;
    endfunction

    // INIT starts in the current cycle: entry i is drawn i ticks later.
    task automatic gen_seq();
        for (int i = 0; i < ml; i++) begin
            seq[i] = int'(lfsr_at(tick_no + i)) & mask;
        end
    endtask

    // Random button pulse that the controller must ignore.
    task automatic noise();
        if ($urandom_range(0, 3) == 0) begin
            bv   = 1'b1;
            bval = 3'($urandom);
        end
    endtask

    task automatic init_phase();
        for (int i = 0; i < ml; i++) begin
            chk("init_state", o_state, 0);
            chk("init_round", o_round, 0);
            noise();
            tick();
            bv = 1'b0;
        end
        chk("init_exit_state", o_state, 1);
        chk("init_exit_round", o_round, 1);
    endtask

    // Expects the first PLAY_ON cycle of round r; ends on the first WAIT cycle.
    task automatic play_round(input int r);
        for (int s = 0; s < r; s++) begin
            for (int h = 0; h < hold; h++) begin
                chk("play_state", o_state, 1);
                chk("play_led", o_led, 1 << seq[s]);
                chk("play_round", o_round, r);
                noise();
                tick();
                bv = 1'b0;
            end
            for (int g = 0; g < gap; g++) begin
                chk("gap_state", o_state, 2);
                chk("gap_led", o_led, 0);
                noise();
                tick();
                bv = 1'b0;
            end
        end
        chk("wait_entry", o_state, 3);
        chk("wait_led", o_led, 0);
    endtask

    task automatic do_press(input int i, input int r, input int delay, input bit wrong);
        logic [2:0] v;
        chk("wait_state", o_state, 3);
        chk("exp_val", o_exp, seq[i]);
        chk("wait_err", o_err, 0);
        for (int d = 0; d < delay; d++) begin
            tick();
            chk("wait_hold", o_state, 3);
        end
        v = 3'(seq[i]);
        if (wrong) v = 3'((seq[i] + 1 + $urandom_range(0, nb - 2)) & mask);
        bv   = 1'b1;
        bval = v;
        tick();
        bv = 1'b0;
        chk("check_state", o_state, 4);
        noise();
        tick();
        bv = 1'b0;
        if (wrong) begin
            chk("err_state", o_state, 5);
            chk("err_led", o_err, 1);
        end else if (i < r - 1) begin
            chk("next_wait", o_state, 3);
        end else if (r < ml) begin
            chk("next_round_state", o_state, 1);
            chk("next_round_cnt", o_round, r + 1);
        end else begin
            chk("win_state", o_state, 6);
            chk("win_led", o_win, 1);
            chk("win_leds", o_led, (1 << nb) - 1);
        end
    endtask

    task automatic game_round(input int r);
        play_round(r);
        for (int i = 0; i < r; i++) begin
            do_press(i, r, $urandom_range(0, 5), 1'b0);
        end
    endtask

    task automatic press_any();
        bv   = 1'b1;
        bval = 3'($urandom);
        tick();
        bv = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; bv = 1'b0; bval = '0; sel = 1'b0;
        tick_no = 0;
        ml = 16; nb = 4; mask = 3; hold = 6; gap = 2; tmo = 192;

        // Reset state of the default instance.
        repeat (3) tick();
        chk("rst_state", o_state, 0);
        chk("rst_led", o_led, 0);
        chk("rst_err", o_err, 0);
        chk("rst_win", o_win, 0);
        chk("rst_round", o_round, 0);

        // Release, fill, then full 16-round win with ignored noise pulses.
        rst_a = 1'b0;
        tick_no = 0;
        gen_seq();
        init_phase();
        for (int r = 1; r <= ml; r++) game_round(r);

        // Win acknowledged: back to INIT with a fresh draw.
        press_any();
        chk("restart_state", o_state, 0);
        chk("restart_round", o_round, 0);
        chk("restart_win", o_win, 0);
        chk("restart_led", o_led, 0);
        gen_seq();
        init_phase();

        // Wrong second press in round 3, then retry replays seq[0].
        game_round(1);
        game_round(2);
        play_round(3);
        do_press(0, 3, $urandom_range(0, 5), 1'b0);
        do_press(1, 3, $urandom_range(0, 5), 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("err_hold_state", o_state, 5);
            chk("err_hold_led", o_err, 1);
        end
        press_any();
        chk("retry_state", o_state, 1);
        chk("retry_err", o_err, 0);
        chk("retry_round", o_round, 1);
        play_round(1);

        // Timeout: error appears exactly tmo ticks after WAIT entry.
        for (int k = 0; k < tmo; k++) begin
            chk("to_state", o_state, 3);
            chk("to_err", o_err, 0);
            tick();
        end
        chk("to_fire_state", o_state, 5);
        chk("to_fire_err", o_err, 1);

        // Press on the last allowed tick beats the timeout.
        press_any();
        play_round(1);
        do_press(0, 1, tmo - 1, 1'b0);

        // Small instance: 8 buttons, 1-tick LEDs, 4-step game.
        rst_a = 1'b1;
        sel = 1'b1;
        ml = 4; nb = 8; mask = 7; hold = 1; gap = 2;
        tick();
        rst_b = 1'b0;
        tick_no = 0;
        gen_seq();
        init_phase();
        for (int r = 1; r <= ml; r++) game_round(r);
        press_any();
        chk("b_restart_state", o_state, 0);
        gen_seq();
        init_phase();
        game_round(1);
        game_round(2);
        tick();
        tick();

        // Reset mid-round 3 clears everything at once.
        rst_b = 1'b1;
        #1;
        chk("b_rst_state", o_state, 0);
        chk("b_rst_led", o_led, 0);
        chk("b_rst_err", o_err, 0);
        chk("b_rst_win", o_win, 0);
        chk("b_rst_round", o_round, 0);
        tick();
        rst_b = 1'b0;
        tick_no = 0;
        gen_seq();
        init_phase();
        play_round(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
